// File: rtl/redirect_apply_stage_if.sv
// ID/EX redirect-apply bus: decode-side inputs, hazard controls
// and the registered ID/EX outputs.
interface redirect_apply_stage_if #(
    parameter int DW   = 32,
    parameter int CNTW = 16
);
    logic            in_EN;
    logic            in_BEN;
    logic            in_DECLR;
    logic            in_FDCLR;
    logic [3:0]      in_ALUREDI;
    logic [1:0]      in_CSW;
    logic [31:0]     in_IS;
    logic [DW-1:0]   in_PC;
    logic [DW-1:0]   in_RS_DATA;
    logic [DW-1:0]   in_RT_DATA;
    logic [DW-1:0]   in_PP_RESULT;
    logic [DW-1:0]   in_PPP_RESULT;
    logic [31:0]     out_PIS;
    logic [DW-1:0]   out_PPC;
    logic [DW-1:0]   out_A;
    logic [DW-1:0]   out_B;
    logic [DW-1:0]   out_SWDATA;
    logic            out_VALID;
    logic [CNTW-1:0] out_STALLCNT;
    logic [CNTW-1:0] out_BUBBLECNT;
    logic            out_STALL_ERR;

    modport master (
        output in_EN, in_BEN, in_DECLR, in_FDCLR, in_ALUREDI, in_CSW,
        output in_IS, in_PC, in_RS_DATA, in_RT_DATA,
        output in_PP_RESULT, in_PPP_RESULT,
        input  out_PIS, out_PPC, out_A, out_B, out_SWDATA, out_VALID,
        input  out_STALLCNT, out_BUBBLECNT, out_STALL_ERR
    );

    modport slave (
        input  in_EN, in_BEN, in_DECLR, in_FDCLR, in_ALUREDI, in_CSW,
        input  in_IS, in_PC, in_RS_DATA, in_RT_DATA,
        input  in_PP_RESULT, in_PPP_RESULT,
        output out_PIS, out_PPC, out_A, out_B, out_SWDATA, out_VALID,
        output out_STALLCNT, out_BUBBLECNT, out_STALL_ERR
    );
endinterface

// File: rtl/redirect_apply_stage.sv
// ID/EX register applying hazard-unit stall, bubble, flush and
// forwarding selects, with stall/bubble statistics.
module redirect_apply_stage #(
    parameter int DW        = 32,
    parameter int CNTW      = 16,
    parameter int MAX_STALL = 8
) (
    input  logic                  in_CLK,
    input  logic                  in_RST,
    redirect_apply_stage_if.slave bus
);
    localparam int RW = $clog2(MAX_STALL + 2);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_flush;
    logic            w_clr;
    logic            w_hold;
    logic            w_load;
    logic [DW-1:0]   w_a;
    logic [DW-1:0]   w_b;
    logic [DW-1:0]   w_sw;
    logic [31:0]     r_pis;
    logic [DW-1:0]   r_ppc;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_sw;
    logic            r_valid;
    logic [CNTW-1:0] r_scnt;
    logic [CNTW-1:0] r_bcnt;
    logic [RW-1:0]   r_run;
    logic            r_err;

    assign w_flush = bus.in_FDCLR | bus.in_DECLR;

    always_ff @(posedge in_CLK or negedge in_RST) begin
        if (!in_RST)
            r_state <= IDLE;
        else if (bus.in_EN)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = RUN;
            RUN:     if (!bus.in_BEN && !w_flush) w_next = HOLD;
            HOLD:    if (bus.in_BEN || w_flush) w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    // Flush/clear outranks a stall, so a bubble always ends a hold.
    always_comb begin
        w_clr  = 1'b0;
        w_hold = 1'b0;
        w_load = 1'b0;
        if (bus.in_EN) begin
            if (w_flush)
                w_clr = 1'b1;
            else if (!bus.in_BEN)
                w_hold = 1'b1;
            else
                w_load = 1'b1;
        end
    end

    assign w_a = bus.in_ALUREDI[0] ? bus.in_PP_RESULT :
                 bus.in_ALUREDI[2] ? bus.in_PPP_RESULT : bus.in_RS_DATA;
    assign w_b = bus.in_ALUREDI[1] ? bus.in_PP_RESULT :
                 bus.in_ALUREDI[3] ? bus.in_PPP_RESULT : bus.in_RT_DATA;
    assign w_sw = bus.in_CSW[0] ? bus.in_PP_RESULT :
                  bus.in_CSW[1] ? bus.in_PPP_RESULT : bus.in_RT_DATA;

    always_ff @(posedge in_CLK or negedge in_RST) begin
        if (!in_RST) begin
            r_pis   <= '0;
            r_ppc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sw    <= '0;
            r_valid <= 1'b0;
        end else if (w_clr) begin
            r_pis   <= '0;
            r_ppc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sw    <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_pis   <= bus.in_IS;
            r_ppc   <= bus.in_PC;
            r_a     <= w_a;
            r_b     <= w_b;
            r_sw    <= w_sw;
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge in_CLK or negedge in_RST) begin
        if (!in_RST) begin
            r_scnt <= '0;
            r_bcnt <= '0;
            r_run  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_clr && r_bcnt != '1)
                r_bcnt <= r_bcnt + CNTW'(1);
            if (w_hold && r_scnt != '1)
                r_scnt <= r_scnt + CNTW'(1);
            // Run length saturates one past the limit; the error is sticky.
            if (w_hold) begin
                if (r_run != RW'(MAX_STALL + 1))
                    r_run <= r_run + RW'(1);
                if (r_run == RW'(MAX_STALL))
                    r_err <= 1'b1;
            end else if (bus.in_EN) begin
                r_run <= '0;
            end
        end
    end

    assign bus.out_PIS       = r_pis;
    assign bus.out_PPC       = r_ppc;
    assign bus.out_A         = r_a;
    assign bus.out_B         = r_b;
    assign bus.out_SWDATA    = r_sw;
    assign bus.out_VALID     = r_valid;
    assign bus.out_STALLCNT  = r_scnt;
    assign bus.out_BUBBLECNT = r_bcnt;
    assign bus.out_STALL_ERR = r_err;
endmodule

// File: tb/tb_redirect_apply_stage.sv
// Directed-vector bench for redirect_apply_stage: a wide-counter
// instance plus a CNTW=2 instance sharing the same stimulus.
module tb_redirect_apply_stage;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    redirect_apply_stage_if #(.DW(32), .CNTW(16)) b ();
    redirect_apply_stage_if #(.DW(32), .CNTW(2))  b2 ();

    assign b2.in_EN         = b.in_EN;
    assign b2.in_BEN        = b.in_BEN;
    assign b2.in_DECLR      = b.in_DECLR;
    assign b2.in_FDCLR      = b.in_FDCLR;
    assign b2.in_ALUREDI    = b.in_ALUREDI;
    assign b2.in_CSW        = b.in_CSW;
    assign b2.in_IS         = b.in_IS;
    assign b2.in_PC         = b.in_PC;
    assign b2.in_RS_DATA    = b.in_RS_DATA;
    assign b2.in_RT_DATA    = b.in_RT_DATA;
    assign b2.in_PP_RESULT  = b.in_PP_RESULT;
    assign b2.in_PPP_RESULT = b.in_PPP_RESULT;

    redirect_apply_stage dut (
        .in_CLK (clk),
        .in_RST (rst_n),
        .bus    (b)
    );

    redirect_apply_stage #(.CNTW(2)) dut2 (
        .in_CLK (clk),
        .in_RST (rst_n),
        .bus    (b2)
    );

    typedef struct {
        logic        en, ben, dc, fc;
        logic [3:0]  alu;
        logic [1:0]  csw;
        logic [31:0] is, pc;
        logic [31:0] pis, ppc, a, bb, sw;
        logic        v;
        logic [15:0] sc, bc;
        logic        err;
    } vec_t;

    vec_t tv [17];

    function automatic vec_t mk(
        logic en, logic ben, logic dc, logic fc,
        logic [3:0] alu, logic [1:0] csw,
        logic [31:0] is, logic [31:0] pc,
        logic [31:0] pis, logic [31:0] ppc,
        logic [31:0] a, logic [31:0] bb, logic [31:0] sw,
        logic v, logic [15:0] sc, logic [15:0] bc, logic err);
        vec_t t;
        t.en = en; t.ben = ben; t.dc = dc; t.fc = fc;
        t.alu = alu; t.csw = csw; t.is = is; t.pc = pc;
        t.pis = pis; t.ppc = ppc; t.a = a; t.bb = bb; t.sw = sw;
        t.v = v; t.sc = sc; t.bc = bc; t.err = err;
        return t;
    endfunction

    function automatic logic [255:0] got1();
        return 256'({b.out_PIS, b.out_PPC, b.out_A, b.out_B,
                      b.out_SWDATA, b.out_VALID, b.out_STALLCNT,
                      b.out_BUBBLECNT, b.out_STALL_ERR});
    endfunction

    function automatic logic [255:0] exp1(
        logic [31:0] pis, logic [31:0] ppc, logic [31:0] a,
        logic [31:0] bb, logic [31:0] sw, logic v,
        logic [15:0] sc, logic [15:0] bc, logic err);
        return 256'({pis, ppc, a, bb, sw, v, sc, bc, err});
    endfunction

    function automatic logic [255:0] got2();
        return 256'({b2.out_PIS, b2.out_VALID, b2.out_STALLCNT,
                      b2.out_BUBBLECNT, b2.out_STALL_ERR});
    endfunction

    task automatic chk(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = mk(1,1,0,0,4'b0000,2'b00,32'h00221820,32'h100,
                    32'h00221820,32'h100,5,7,7,1,0,0,0);
        tv[1]  = mk(1,1,0,0,4'b0101,2'b00,32'h11,32'h104,
                    32'h11,32'h104,32'h10,7,7,1,0,0,0);
        tv[2]  = mk(1,1,0,0,4'b0100,2'b00,32'h12,32'h108,
                    32'h12,32'h108,32'h20,7,7,1,0,0,0);
        tv[3]  = mk(1,1,0,0,4'b1010,2'b00,32'h13,32'h10c,
                    32'h13,32'h10c,5,32'h10,7,1,0,0,0);
        tv[4]  = mk(1,1,0,0,4'b1000,2'b01,32'h14,32'h110,
                    32'h14,32'h110,5,32'h20,32'h10,1,0,0,0);
        tv[5]  = mk(1,1,0,0,4'b0000,2'b10,32'h15,32'h114,
                    32'h15,32'h114,5,7,32'h20,1,0,0,0);
        tv[6]  = mk(1,1,0,0,4'b1111,2'b11,32'h16,32'h118,
                    32'h16,32'h118,32'h10,32'h10,32'h10,1,0,0,0);
        tv[7]  = mk(0,1,0,0,4'b0000,2'b00,32'h99,32'h999,
                    32'h16,32'h118,32'h10,32'h10,32'h10,1,0,0,0);
        tv[8]  = mk(1,0,0,0,4'b0000,2'b00,32'h17,32'h11c,
                    32'h16,32'h118,32'h10,32'h10,32'h10,1,1,0,0);
        tv[9]  = mk(1,0,0,0,4'b0000,2'b00,32'h17,32'h11c,
                    32'h16,32'h118,32'h10,32'h10,32'h10,1,2,0,0);
        tv[10] = mk(1,0,0,0,4'b0000,2'b00,32'h17,32'h11c,
                    32'h16,32'h118,32'h10,32'h10,32'h10,1,3,0,0);
        tv[11] = mk(1,1,0,0,4'b0000,2'b00,32'h17,32'h11c,
                    32'h17,32'h11c,5,7,7,1,3,0,0);
        tv[12] = mk(1,1,1,1,4'b0101,2'b01,32'h55,32'h55,
                    0,0,0,0,0,0,3,1,0);
        tv[13] = mk(1,0,1,0,4'b0000,2'b00,32'h56,32'h56,
                    0,0,0,0,0,0,3,2,0);
        tv[14] = mk(1,0,0,0,4'b0000,2'b00,32'h57,32'h57,
                    0,0,0,0,0,0,4,2,0);
        tv[15] = mk(1,0,0,1,4'b0000,2'b00,32'h58,32'h58,
                    0,0,0,0,0,0,4,3,0);
        tv[16] = mk(1,1,0,0,4'b0000,2'b00,32'h18,32'h120,
                    32'h18,32'h120,5,7,7,1,4,3,0);

        b.in_EN = 0; b.in_BEN = 1; b.in_DECLR = 0; b.in_FDCLR = 0;
        b.in_ALUREDI = '0; b.in_CSW = '0;
        b.in_IS = 32'h00221820; b.in_PC = 32'h100;
        b.in_RS_DATA = 5; b.in_RT_DATA = 7;
        b.in_PP_RESULT = 32'h10; b.in_PPP_RESULT = 32'h20;

        #12;
        chk("reset", got1(), 256'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("idle_en0", got1(), 256'(0));

        foreach (tv[i]) begin
            b.in_EN = tv[i].en; b.in_BEN = tv[i].ben;
            b.in_DECLR = tv[i].dc; b.in_FDCLR = tv[i].fc;
            b.in_ALUREDI = tv[i].alu; b.in_CSW = tv[i].csw;
            b.in_IS = tv[i].is; b.in_PC = tv[i].pc;
            step();
            chk($sformatf("vec%0d", i), got1(),
                exp1(tv[i].pis, tv[i].ppc, tv[i].a, tv[i].bb, tv[i].sw,
                     tv[i].v, tv[i].sc, tv[i].bc, tv[i].err));
        end

        b.in_IS = 32'hdead; b.in_RS_DATA = 1;
        #2;
        chk("no_comb", 256'({b.out_PIS, b.out_A}), 256'({32'h18, 32'd5}));
        b.in_RS_DATA = 5; b.in_IS = 32'h19; b.in_PC = 32'h124;

        b.in_BEN = 0; repeat (8) step();
        b.in_BEN = 1; step();
        b.in_BEN = 0; repeat (8) step();
        chk("run_reset", 256'({b.out_STALL_ERR, b.out_STALLCNT}),
            256'({1'b0, 16'd20}));
        b.in_BEN = 1; step();
        b.in_BEN = 0; repeat (8) step();
        chk("hold8", 256'({b.out_STALL_ERR, b.out_STALLCNT}),
            256'({1'b0, 16'd28}));
        step();
        chk("hold9", 256'({b.out_STALL_ERR, b.out_STALLCNT, b.out_PIS}),
            256'({1'b1, 16'd29, 32'h19}));
        b.in_BEN = 1; step();
        chk("err_sticky", 256'({b.out_STALL_ERR, b.out_VALID}),
            256'({1'b1, 1'b1}));

        b.in_BEN = 0; step();
        chk("sat_cntw2", got2(),
            256'({32'h19, 1'b1, 2'd3, 2'd3, 1'b1}));
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst", got1(), 256'(0));
        chk("async_rst2", got2(), 256'(0));
        step();
        chk("rst_over_edge", got1(), 256'(0));
        rst_n = 1'b1;
        b.in_EN = 0; b.in_BEN = 1;
        step();
        chk("idle_after_rst", got1(), 256'(0));
        b.in_EN = 1; b.in_IS = 32'h00221820; b.in_PC = 32'h200;
        step();
        chk("reload", got1(),
            exp1(32'h00221820, 32'h200, 5, 7, 7, 1, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
